// File: rtl/ri5cy_arb_pkg.sv
// Shared types and helpers for the RI5CY two-port memory arbiter.
package ri5cy_arb_pkg;

    typedef logic [0:0] port_idx_t;

    localparam port_idx_t PORT_INSTR = 1'b0;
    localparam port_idx_t PORT_DATA  = 1'b1;

    // Width needed to hold a count in the range 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ri5cy_arb_id_fifo.sv
// In-order FIFO of port indices for granted-but-unanswered transfers.
module ri5cy_arb_id_fifo
    import ri5cy_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      push,
    input  port_idx_t push_id,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output port_idx_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    port_idx_t       mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : (p + PW'(1));
    endfunction

    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign head   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= PORT_INSTR;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_id;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ri5cy_mem_arbiter.sv
// Two-port (instr/data) arbiter onto one RI5CY req/gnt/rvalid memory port.
// Define RI5CY_ARB_RR_EN for round-robin; otherwise data has fixed priority.
module ri5cy_mem_arbiter
    import ri5cy_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [1:0]                        req_i,
    input  logic [1:0]                        we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]      be_i,
    input  logic [1:0][ADDR_WIDTH-1:0]        addr_i,
    input  logic [1:0][DATA_WIDTH-1:0]        wdata_i,
    output logic [1:0]                        gnt_o,
    output logic [1:0]                        rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              req_o,
    output logic                              we_o,
    output logic [DATA_WIDTH/8-1:0]           be_o,
    output logic [ADDR_WIDTH-1:0]             addr_o,
    output logic [DATA_WIDTH-1:0]             wdata_o,
    input  logic                              gnt_i,
    input  logic                              rvalid_i,
    input  logic [DATA_WIDTH-1:0]             rdata_i,
    output logic                              spurious_o
);

    port_idx_t winner_s;
    port_idx_t head_s;
    logic      fifo_full_s;
    logic      fifo_empty_s;
    logic      accept_s;
    logic      pop_s;
    logic      spurious_r;

`ifdef RI5CY_ARB_RR_EN
    port_idx_t last_r;

    // Round-robin: on a conflict the port not granted last wins; idle selects port 0.
    always_comb begin
        winner_s = PORT_INSTR;
        case (req_i)
            2'b01:   winner_s = PORT_INSTR;
            2'b10:   winner_s = PORT_DATA;
            2'b11:   winner_s = ~last_r;
            default: winner_s = PORT_INSTR;
        endcase
    end

    // Last-grant pointer moves only when a transfer is actually accepted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_r <= PORT_INSTR;
        end else if (accept_s) begin
            last_r <= winner_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    // Fixed priority: data always beats instruction fetch; idle selects port 0.
    always_comb begin
        winner_s = PORT_INSTR;
        case (req_i)
            2'b10, 2'b11: winner_s = PORT_DATA;
            default:      winner_s = PORT_INSTR;
        endcase
    end
`endif

    // A full FIFO blocks the request even if a response frees a slot this cycle.
    assign req_o    = (|req_i) & ~fifo_full_s;
    assign accept_s = req_o & gnt_i;
    assign pop_s    = rvalid_i & ~fifo_empty_s;

    assign we_o    = we_i[winner_s];
    assign be_o    = be_i[winner_s];
    assign addr_o  = addr_i[winner_s];
    assign wdata_o = wdata_i[winner_s];
    assign rdata_o = rdata_i;

    // Grant goes to the winner, response to the port at the head of the ID FIFO.
    always_comb begin
        gnt_o    = 2'b00;
        rvalid_o = 2'b00;
        if (accept_s) begin
            gnt_o[winner_s] = 1'b1;
        end else begin
            gnt_o = 2'b00;
        end
        if (pop_s) begin
            rvalid_o[head_s] = 1'b1;
        end else begin
            rvalid_o = 2'b00;
        end
    end

    // Sticky flag for a response that matches no outstanding transfer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            spurious_r <= 1'b0;
        end else if (rvalid_i && fifo_empty_s) begin
            spurious_r <= 1'b1;
        end else begin
            spurious_r <= spurious_r;
        end
    end

    assign spurious_o = spurious_r;

    ri5cy_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (accept_s),
        .push_id (winner_s),
        .pop     (pop_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .head    (head_s)
    );

endmodule
